// File: rtl/gate_chk_pkg.sv
//==============================================================================
// Module : gate_chk_pkg
// Brief  : Shared state encoding and reference truth tables for gate checking.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SETTLE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_OR3   = 8'hFE;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_XOR3  = 8'h96;

endpackage

`default_nettype wire

// File: rtl/gate_chk_timer.sv
//==============================================================================
// Module : gate_chk_timer
// Brief  : Loadable settle down-counter plus clearable idle counter, each with
//          a terminal-count flag.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate_chk_timer #(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_settle_load,
  input  logic i_settle_dec,
  input  logic i_idle_clr,
  output logic o_settle_tc,
  output logic o_idle_tc
);

  localparam logic [3:0] c_SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam logic [7:0] c_IDLE_LAST   = 8'(TIMEOUT_CYC - 1);

  logic [3:0] r_settle_cnt;
  logic [7:0] r_idle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= 4'd0;
      r_idle_cnt   <= 8'd0;
    end else begin
      if (i_settle_load) begin
        r_settle_cnt <= c_SETTLE_LOAD;
      end else if (i_settle_dec && (r_settle_cnt != 4'd0)) begin
        r_settle_cnt <= r_settle_cnt - 4'd1;
      end
      if (i_idle_clr) begin
        r_idle_cnt <= 8'd0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end
    end
  end

  // The sample is taken on the cycle the count reads 1, i.e. SETTLE_CYC edges after load.
  assign o_settle_tc = (r_settle_cnt == 4'd1);
  assign o_idle_tc   = (r_idle_cnt == c_IDLE_LAST);

endmodule

`default_nettype wire

// File: rtl/gate3_response_checker.sv
//==============================================================================
// Module : gate3_response_checker
// Brief  : Samples a 3-input gate's response per vector after a settle delay,
//          builds its truth table and compares it against EXPECTED_TT.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gate3_response_checker
  import gate_chk_pkg::*;
#(
  parameter logic [7:0]  EXPECTED_TT = TT_NAND3,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vec_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       dut_out,
  output logic [7:0] truth_table,
  output logic [7:0] seen_mask,
  output logic [7:0] mismatch_mask,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_overrun,
  output logic       err_conflict,
  output logic       err_timeout
);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_idx;
  logic [7:0] r_tt;
  logic [7:0] r_seen;
  logic [7:0] r_mm;
  logic       r_err_ovr;
  logic       r_err_conf;
  logic       r_err_to;

  logic       w_settle_load;
  logic       w_sample;
  logic       w_timeout;
  logic       w_overrun;
  logic       w_settle_tc;
  logic       w_idle_tc;
  logic       w_idle_clr;
  logic [7:0] w_idx_bit;
  logic [7:0] w_seen_upd;

  assign w_idx_bit  = 8'd1 << r_idx;
  assign w_seen_upd = r_seen | w_idx_bit;
  assign w_idle_clr = (r_state != COLLECT) || vec_valid || start;

  gate_chk_timer #(
    .SETTLE_CYC  (SETTLE_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .i_settle_load (w_settle_load),
    .i_settle_dec  (r_state == SETTLE),
    .i_idle_clr    (w_idle_clr),
    .o_settle_tc   (w_settle_tc),
    .o_idle_tc     (w_idle_tc)
  );

  always_comb begin
    w_state_next  = r_state;
    w_settle_load = 1'b0;
    w_sample      = 1'b0;
    w_timeout     = 1'b0;
    w_overrun     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = COLLECT;
      end
      COLLECT: begin
        if (start) begin
          w_state_next = COLLECT;
        end else if (vec_valid) begin
          w_state_next  = SETTLE;
          w_settle_load = 1'b1;
        end else if (w_idle_tc) begin
          w_state_next = DONE;
          w_timeout    = 1'b1;
        end
      end
      SETTLE: begin
        if (start) begin
          w_state_next = COLLECT;
        end else begin
          w_overrun = vec_valid;
          if (w_settle_tc) begin
            w_sample     = 1'b1;
            w_state_next = (w_seen_upd == 8'hFF) ? DONE : COLLECT;
          end
        end
      end
      DONE: begin
        if (start) w_state_next = COLLECT;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_idx      <= 3'd0;
      r_tt       <= 8'd0;
      r_seen     <= 8'd0;
      r_mm       <= 8'd0;
      r_err_ovr  <= 1'b0;
      r_err_conf <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      if (w_settle_load) r_idx <= {a, b, c};
      // Only the first sample of an index is kept; later ones are consistency checks.
      if (w_sample) begin
        if (!r_seen[r_idx]) begin
          r_tt[r_idx]   <= dut_out;
          r_seen[r_idx] <= 1'b1;
          r_mm[r_idx]   <= dut_out ^ EXPECTED_TT[r_idx];
        end else if (dut_out != r_tt[r_idx]) begin
          r_err_conf <= 1'b1;
        end
      end
      if (w_overrun) r_err_ovr <= 1'b1;
      if (w_timeout) r_err_to  <= 1'b1;
    end
  end

  assign truth_table   = r_tt;
  assign seen_mask     = r_seen;
  assign mismatch_mask = r_mm;
  assign err_overrun   = r_err_ovr;
  assign err_conflict  = r_err_conf;
  assign err_timeout   = r_err_to;
  assign busy          = (r_state == COLLECT) || (r_state == SETTLE);
  assign done          = (r_state == DONE);
  assign pass          = done && (r_seen == 8'hFF) && (r_mm == 8'h00) &&
                         !r_err_ovr && !r_err_conf && !r_err_to;

endmodule

`default_nettype wire

// File: tb/tb_gate3_response_checker.sv
//==============================================================================
// Module : tb_gate3_response_checker
// Brief  : Scoreboard bench: driver predicts each run's outcome from the
//          checker's rules, a monitor compares whenever done rises.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gate3_response_checker;

  localparam int S_CYC = 2;
  localparam int T_CYC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       dut_out = 1'b0;
  logic [7:0] truth_table, seen_mask, mismatch_mask;
  logic       busy, done, pass, err_overrun, err_conflict, err_timeout;

  gate3_response_checker #(
    .EXPECTED_TT (8'h7F),
    .SETTLE_CYC  (S_CYC),
    .TIMEOUT_CYC (T_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vec_valid     (vec_valid),
    .a             (a),
    .b             (b),
    .c             (c),
    .dut_out       (dut_out),
    .truth_table   (truth_table),
    .seen_mask     (seen_mask),
    .mismatch_mask (mismatch_mask),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_overrun   (err_overrun),
    .err_conflict  (err_conflict),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tt;
    logic [7:0] seen;
    logic [7:0] mm;
    logic       ovr;
    logic       conf;
    logic       to;
    logic       pass;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pushed = 0;
  int   n_done_seen = 0;
  int   edge_n = 0;

  // Reference model of one run
  logic [7:0] exp_tt_v = 8'h7F;
  logic [7:0] m_tt, m_seen, m_mm;
  logic       m_ovr, m_conf, m_to, m_fin;
  int         last_acc;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic gate_fn(input int kind, input logic [2:0] v);
    case (kind)
      0:       return v[2] & v[1] & v[0];
      1:       return ~(v[2] & v[1] & v[0]);
      2:       return v[2] | v[1] | v[0];
      3:       return ~(v[2] | v[1] | v[0]);
      default: return v[2] ^ v[1] ^ v[0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic push_expected();
    exp_t e;
    e.tt   = m_tt;
    e.seen = m_seen;
    e.mm   = m_mm;
    e.ovr  = m_ovr;
    e.conf = m_conf;
    e.to   = m_to;
    e.pass = (m_seen == 8'hFF) && (m_mm == 8'h00) && !m_ovr && !m_conf && !m_to;
    q.push_back(e);
    n_pushed++;
  endtask

  task automatic model_clear();
    m_tt = 8'h00; m_seen = 8'h00; m_mm = 8'h00;
    m_ovr = 1'b0; m_conf = 1'b0; m_to = 1'b0; m_fin = 1'b0;
    last_acc = -100;
  endtask

  // start pulse, optionally with a coincident vector that must be dropped
  task automatic begin_run(input bit with_vec, input logic [2:0] idx);
    model_clear();
    start = 1'b1;
    if (with_vec) begin
      vec_valid = 1'b1;
      {a, b, c} = idx;
      dut_out   = 1'($urandom);
    end
    tick();
    start = 1'b0;
    vec_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] idx, input logic val, input int gap);
    bit acc;
    if (m_fin) return;
    // A vector is taken only once the previous one has been sampled
    acc = (edge_n + 1) > (last_acc + S_CYC);
    {a, b, c} = idx;
    vec_valid = 1'b1;
    if (acc) dut_out = val;
    tick();
    vec_valid = 1'b0;
    if (acc) begin
      last_acc = edge_n;
      if (!m_seen[idx]) begin
        m_tt[idx]   = val;
        m_seen[idx] = 1'b1;
        m_mm[idx]   = val ^ exp_tt_v[idx];
      end else if (m_tt[idx] != val) begin
        m_conf = 1'b1;
      end
      if (m_seen == 8'hFF) begin
        m_fin = 1'b1;
        push_expected();
      end
    end else begin
      m_ovr = 1'b1;
    end
    repeat (gap - 1) tick();
  endtask

  task automatic sweep(input int kind, input int gap);
    for (int i = 0; i < 8; i++) send(3'(i), gate_fn(kind, 3'(i)), gap);
  endtask

  task automatic finish_run();
    if (!m_fin) begin
      m_to = 1'b1;
      push_expected();
    end
    for (int k = 0; k < T_CYC + 40 && n_done_seen < n_pushed; k++) tick();
    if (n_done_seen < n_pushed) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=%b expected done=1 within %0d cycles", done, T_CYC + 40);
      q.delete();
      n_done_seen = n_pushed;
    end
    repeat (3) tick();
  endtask

  task automatic check_zero();
    chk("rst_truth_table", truth_table, 8'h00);
    chk("rst_seen_mask", seen_mask, 8'h00);
    chk("rst_mismatch_mask", mismatch_mask, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_pass", {7'd0, pass}, 8'h00);
    chk("rst_err_overrun", {7'd0, err_overrun}, 8'h00);
    chk("rst_err_conflict", {7'd0, err_conflict}, 8'h00);
    chk("rst_err_timeout", {7'd0, err_timeout}, 8'h00);
  endtask

  // Monitor: one scoreboard entry per rising edge of done
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no completed run");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("truth_table", truth_table, e.tt);
        chk("seen_mask", seen_mask, e.seen);
        chk("mismatch_mask", mismatch_mask, e.mm);
        chk("err_overrun", {7'd0, err_overrun}, {7'd0, e.ovr});
        chk("err_conflict", {7'd0, err_conflict}, {7'd0, e.conf});
        chk("err_timeout", {7'd0, err_timeout}, {7'd0, e.to});
        chk("pass", {7'd0, pass}, {7'd0, e.pass});
        chk("busy_at_done", {7'd0, busy}, 8'h00);
        n_done_seen++;
      end
    end
    done_d <= done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected finish before 900000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (3) tick();
    check_zero();
    reset = 1'b0;
    repeat (2) tick();

    // NAND3 in order, then AND3 against the NAND3 expectation
    begin_run(0, 3'd0); sweep(1, 4); finish_run();
    begin_run(0, 3'd0); sweep(0, 4); finish_run();

    // 0..6 only, then silence until timeout
    begin_run(0, 3'd0);
    for (int i = 0; i < 7; i++) send(3'(i), gate_fn(1, 3'(i)), 4);
    finish_run();

    // overrun then a complete sweep
    begin_run(0, 3'd0);
    send(3'd3, gate_fn(1, 3'd3), 1);
    send(3'd4, gate_fn(1, 3'd4), 4);
    sweep(1, 4);
    finish_run();

    // conflicting resample of index 5
    begin_run(0, 3'd0);
    send(3'd5, 1'b0, 4);
    send(3'd5, 1'b1, 4);
    sweep(1, 4);
    finish_run();

    // same-value repeat on index 2 is legal
    begin_run(0, 3'd0);
    send(3'd2, 1'b1, 4);
    send(3'd2, 1'b1, 4);
    sweep(1, 4);
    finish_run();

    // reset while settling aborts the run
    begin_run(0, 3'd0);
    {a, b, c} = 3'd3; dut_out = 1'b1; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_zero();
    reset = 1'b0;
    tick();
    begin_run(0, 3'd0); sweep(1, 4); finish_run();

    // vector coincident with start is dropped
    begin_run(1, 3'd7);
    for (int i = 0; i < 4; i++) send(3'(i), gate_fn(1, 3'(i)), 3);
    finish_run();

    // randomized runs
    for (int r = 0; r < 24; r++) begin
      int kind, nv;
      kind = int'($urandom_range(0, 4));
      nv   = int'($urandom_range(4, 22));
      begin_run(1'($urandom_range(0, 1)), 3'($urandom));
      for (int v = 0; v < nv; v++) begin
        logic [2:0] idx;
        logic       val;
        int         gap;
        idx = 3'($urandom);
        val = gate_fn(kind, idx) ^ ($urandom_range(0, 15) == 0);
        gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 6));
        send(idx, val, gap);
      end
      finish_run();
    end

    chk("scoreboard_empty", 8'(q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
